// File: rtl/regex_pkg.sv
// Shared types and character constants for the streaming "ab*c" regex checker.
package regex_pkg;

  // DFA states of the unanchored "ab*c" search
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no partial match in progress
    S_A    = 2'd1,  // seen 'a'
    S_B    = 2'd2   // seen 'a' followed by one or more 'b'
  } state_t;

  localparam logic [7:0] CH_A   = 8'h61;
  localparam logic [7:0] CH_B   = 8'h62;
  localparam logic [7:0] CH_C   = 8'h63;
  localparam logic [7:0] CH_NUL = 8'h00;

endpackage

// File: rtl/regex_stream_checker_word_unpacker.sv
// Pops WIDTH-bit words from a first-word-fall-through FIFO and presents them
// one 8-bit character per cycle, least-significant byte first.
module word_unpacker
  import regex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_data,
  output logic             o_fifo_shift_out,
  output logic [7:0]       o_char,
  output logic             o_char_vld,
  output logic             o_busy
);

  localparam int CHARS = WIDTH / 8;
  localparam int IDX_W = (CHARS > 1) ? $clog2(CHARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHARS - 1);

  logic [WIDTH-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             r_loaded;
  logic             w_last;
  logic             w_pop;

  // A new word may be popped when nothing is loaded or the last character is
  // being consumed this cycle, which gives gapless back-to-back words. Reset
  // gates the pop so nothing is taken from the FIFO while it is asserted.
  assign w_last = r_loaded && (r_idx == LAST_IDX);
  assign w_pop  = ~i_rst & i_enable & ~i_fifo_empty & (~r_loaded | w_last);

  // Control: load flag and character index
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_loaded <= 1'b0;
      r_idx    <= '0;
    end else if (w_pop) begin
      r_loaded <= 1'b1;
      r_idx    <= '0;
    end else if (r_loaded) begin
      if (w_last) begin
        r_loaded <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Data: capture the head word in the cycle it is popped
  always_ff @(posedge i_clk) begin
    if (w_pop) begin
      r_word <= i_fifo_data;
    end
  end

  assign o_fifo_shift_out = w_pop;
  assign o_char           = r_word[{r_idx, 3'b000} +: 8];
  assign o_char_vld       = r_loaded;
  assign o_busy           = r_loaded;

endmodule

// File: rtl/regex_stream_checker.sv
// Streaming checker for the pattern "ab*c": unanchored DFA search over the
// byte stream from the FIFO, reporting each match with start/end offsets and
// keeping a saturating match count.
module regex_stream_checker
  import regex_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int POS_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_shift_out,
  output logic             match,
  output logic [POS_W-1:0] match_start,
  output logic [POS_W-1:0] match_end,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  logic [7:0]       w_char;
  logic             w_char_vld;
  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_hit;
  logic             w_load_start;
  logic             w_nul;
  logic [POS_W-1:0] r_pos;
  logic [POS_W-1:0] r_start;
  logic             r_match;
  logic [POS_W-1:0] r_match_start;
  logic [POS_W-1:0] r_match_end;
  logic [CNT_W-1:0] r_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  word_unpacker #(
    .WIDTH(WIDTH)
  ) u_unpacker (
    .i_clk           (clk),
    .i_rst           (res),
    .i_enable        (enable),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_data     (fifo_data),
    .o_fifo_shift_out(fifo_shift_out),
    .o_char          (w_char),
    .o_char_vld      (w_char_vld),
    .o_busy          (busy)
  );

  // DFA next state: 'a' always restarts, 'b'/'c' only advance a partial match,
  // NUL terminates the string; with no character the state holds.
  always_comb begin
    w_state_nxt  = r_state;
    w_hit        = 1'b0;
    w_load_start = 1'b0;
    w_nul        = 1'b0;
    if (w_char_vld) begin
      if (w_char == CH_NUL) begin
        w_state_nxt = S_IDLE;
        w_nul       = 1'b1;
      end else if (w_char == CH_A) begin
        w_state_nxt  = S_A;
        w_load_start = 1'b1;
      end else if ((w_char == CH_B) && (r_state != S_IDLE)) begin
        w_state_nxt = S_B;
      end else if ((w_char == CH_C) && (r_state != S_IDLE)) begin
        w_state_nxt = S_IDLE;
        w_hit       = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // DFA state register
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte offset of the current character and offset of the pending 'a';
  // a NUL restarts the offsets at 0 for the next string
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_pos   <= '0;
      r_start <= '0;
    end else if (w_char_vld) begin
      if (w_nul) begin
        r_pos   <= '0;
        r_start <= '0;
      end else begin
        r_pos <= r_pos + 1'b1;
        if (w_load_start) begin
          r_start <= r_pos;
        end
      end
    end
  end

  // Registered match report; offsets and count hold between matches
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_match       <= 1'b0;
      r_match_start <= '0;
      r_match_end   <= '0;
      r_count       <= '0;
    end else begin
      r_match <= w_hit;
      if (w_hit) begin
        r_match_start <= r_start;
        r_match_end   <= r_pos;
        r_count       <= sat_inc(r_count);
      end
    end
  end

  assign match       = r_match;
  assign match_start = r_match_start;
  assign match_end   = r_match_end;
  assign match_count = r_count;

endmodule

// File: tb/tb_regex_stream_checker.sv
// Bench for regex_stream_checker: a FIFO model feeds words, expected matches
// go into a scoreboard queue and are popped when the DUT pulses match.
module tb_regex_stream_checker;

  localparam int WIDTH = 32;
  localparam int POS_W = 16;
  localparam int CNT_W = 2;
  localparam int CHARS = WIDTH / 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             res;
  logic             enable;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_shift_out;
  logic             match;
  logic [POS_W-1:0] match_start;
  logic [POS_W-1:0] match_end;
  logic [CNT_W-1:0] match_count;
  logic             busy;

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
  } exp_t;

  typedef struct {
    bit          rst;
    int          gap;
    logic [31:0] word;
    int          n;
    logic [15:0] s0;
    logic [15:0] e0;
    logic [15:0] s1;
    logic [15:0] e1;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] fq[$];
  vec_t        tbl[8];
  bit          hold;
  int          cycle;
  int          n_checks;
  int          n_fail;
  int          last_pop;
  int          n_pops;
  int          busy_cnt;
  int          last_match_cycle;
  int          exp_cnt;

  regex_stream_checker #(
    .WIDTH(WIDTH),
    .POS_W(POS_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk           (clk),
    .res           (res),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_data     (fifo_data),
    .fifo_shift_out(fifo_shift_out),
    .match         (match),
    .match_start   (match_start),
    .match_end     (match_end),
    .match_count   (match_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = hold || (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push_exp(input logic [15:0] s, input logic [15:0] e);
    exp_t x;
    x.s = s;
    x.e = e;
    sb.push_back(x);
  endtask

  // One clock cycle: sample outputs mid-cycle, then model the FIFO pop at the edge
  task automatic step();
    bit   pop_now;
    exp_t x;
    @(negedge clk);
    if (match) begin
      check("match_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("match_start", 32'(match_start), 32'(x.s));
        check("match_end", 32'(match_end), 32'(x.e));
        if (exp_cnt < MAXC) exp_cnt++;
        check("match_count", 32'(match_count), exp_cnt);
        last_match_cycle = cycle;
      end
    end
    busy_cnt += int'(busy);
    pop_now = fifo_shift_out;
    if (pop_now) begin
      check("pop_only_when_nonempty", 32'(fifo_empty), 0);
      if (busy) check("back_to_back_spacing", cycle - last_pop, CHARS);
      last_pop = cycle;
      n_pops++;
    end
    @(posedge clk);
    #1;
    cycle++;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((fq.size() != 0 || busy) && k < 100) begin
      step();
      k++;
    end
    check("drain_in_time", 32'(k < 100), 1);
    repeat (3) step();
    check("all_matches_seen", sb.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_match"}, 32'(match), 0);
    check({tag, "_start"}, 32'(match_start), 0);
    check({tag, "_end"}, 32'(match_end), 0);
    check({tag, "_count"}, 32'(match_count), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_shift_out"}, 32'(fifo_shift_out), 0);
  endtask

  task automatic do_reset();
    res = 1'b1;
    #1;
    check_zero("rst");
    exp_cnt  = 0;
    n_pops   = 0;
    busy_cnt = 0;
    step();
    res = 1'b0;
  endtask

  initial begin
    int k;
    res = 1'b1; enable = 1'b1; hold = 1'b0;
    cycle = 0; n_checks = 0; n_fail = 0; last_pop = -100;
    n_pops = 0; busy_cnt = 0; last_match_cycle = -100; exp_cnt = 0;

    // Table: B = split match across words, C = NUL terminator,
    // D = empty-FIFO stall inside S_B, F = counter saturation
    tbl[0] = '{1'b1, 0,  32'h78636178, 1, 16'd1, 16'd2, 16'd0, 16'd0};
    tbl[1] = '{1'b0, 0,  32'h63787862, 0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2] = '{1'b1, 0,  32'h63006261, 0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[3] = '{1'b0, 0,  32'h63626178, 1, 16'd2, 16'd4, 16'd0, 16'd0};
    tbl[4] = '{1'b1, 0,  32'h62626178, 0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[5] = '{1'b0, 10, 32'h78787863, 1, 16'd1, 16'd4, 16'd0, 16'd0};
    tbl[6] = '{1'b1, 0,  32'h63616361, 2, 16'd0, 16'd1, 16'd2, 16'd3};
    tbl[7] = '{1'b0, 0,  32'h63616361, 2, 16'd4, 16'd5, 16'd6, 16'd7};

    // Single "abbc" word: latency, busy length, offsets
    fq.push_back(32'h63626261);
    drive_fifo();
    do_reset();
    push_exp(16'd0, 16'd3);
    repeat (10) step();
    check("A_pop_to_match_latency", last_match_cycle - last_pop, 5);
    check("A_busy_cycles", busy_cnt, CHARS);
    check("A_count", 32'(match_count), 1);

    // Reset mid-word after 'a','b': the trailing 'c' must never be processed
    drain();
    fq.push_back(32'h78636261);
    fq.push_back(32'h78636261);
    fq.push_back(32'h78787863);
    fq.push_back(32'h63626261);
    drive_fifo();
    do_reset();
    push_exp(16'd0, 16'd2);
    k = 0;
    while (n_pops < 2 && k < 40) begin
      step();
      k++;
    end
    check("E_second_pop", n_pops, 2);
    step();
    step();
    check("E_count_before", 32'(match_count), 1);
    res = 1'b1;
    #1;
    check_zero("E_midword_rst");
    exp_cnt = 0;
    step();
    res = 1'b0;
    drive_fifo();
    push_exp(16'd4, 16'd7);
    drain();
    check("E_count_after", 32'(match_count), 1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].rst || tbl[i].gap > 0) drain();
      if (tbl[i].gap > 0) hold = 1'b1;
      fq.push_back(tbl[i].word);
      drive_fifo();
      if (tbl[i].rst) do_reset();
      if (tbl[i].n > 0) push_exp(tbl[i].s0, tbl[i].e0);
      if (tbl[i].n > 1) push_exp(tbl[i].s1, tbl[i].e1);
      if (tbl[i].gap > 0) begin
        for (int g = 0; g < tbl[i].gap; g++) begin
          step();
          check("gap_no_pop", 32'(fifo_shift_out), 0);
        end
        hold = 1'b0;
        drive_fifo();
      end
    end
    drain();
    check("F_count_saturated", 32'(match_count), MAXC);

    // enable low: no pop even with data waiting
    enable = 1'b0;
    fq.push_back(32'h78787878);
    drive_fifo();
    for (int j = 0; j < 3; j++) begin
      step();
      check("enable_low_no_pop", 32'(fifo_shift_out), 0);
    end
    enable = 1'b1;
    drain();
    check("final_count", 32'(match_count), MAXC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
